// File: rtl/zap_regf_multiport.sv
// Register file for the ZAP writeback stage: combinational read ports, two
// prioritised write ports, PC sequencer and a serial post-reset scrub.
module zap_regf_multiport #(
  parameter int PHY_REGS = 46,
  parameter int DATA_WDT = 32,
  parameter int NUM_RD   = 4,
  parameter int BYPASS   = 1,
  parameter int PC_IDX   = 15,
  parameter int RAZ_IDX  = 45,
  localparam int IW      = $clog2(PHY_REGS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NUM_RD*IW-1:0]         i_rd_index,
  output logic [NUM_RD*DATA_WDT-1:0]   o_rd_data,
  input  logic                         i_wr_en0,
  input  logic [IW-1:0]                i_wr_index0,
  input  logic [DATA_WDT-1:0]          i_wr_data0,
  input  logic                         i_wr_en1,
  input  logic [IW-1:0]                i_wr_index1,
  input  logic [DATA_WDT-1:0]          i_wr_data1,
  input  logic                         i_pc_load,
  input  logic [DATA_WDT-1:0]          i_pc_load_value,
  input  logic                         i_pc_stall,
  input  logic                         i_thumb,
  output logic [DATA_WDT-1:0]          o_pc,
  output logic                         o_clear_from_writeback,
  output logic                         o_init_busy
);

  // state | meaning
  // INIT  | scrubbing r[cnt] to zero, one register per cycle; ports ignored
  // RUN   | normal operation
  typedef enum logic {INIT, RUN} state_t;

  state_t              state_ff, state_nxt;
  logic [IW-1:0]       cnt_ff, cnt_nxt;
  logic [DATA_WDT-1:0] r_ff  [PHY_REGS];
  logic [DATA_WDT-1:0] r_nxt [PHY_REGS];
  logic [DATA_WDT-1:0] pc_ff, pc_raw, pc_nxt;
  logic                run, wr0_ok, wr1_ok, wr0_pc, wr1_pc;
  logic [IW-1:0]       rd_idx;
  logic [DATA_WDT-1:0] rd_val;

  function automatic logic legal_idx(input logic [IW-1:0] idx);
    return (32'(idx) < PHY_REGS) && (32'(idx) != RAZ_IDX);
  endfunction

  assign run    = (state_ff == RUN);
  assign wr0_ok = run && i_wr_en0 && legal_idx(i_wr_index0);
  assign wr1_ok = run && i_wr_en1 && legal_idx(i_wr_index1);
  assign wr0_pc = wr0_ok && (32'(i_wr_index0) == PC_IDX);
  assign wr1_pc = wr1_ok && (32'(i_wr_index1) == PC_IDX);

  assign pc_ff                  = r_ff[PC_IDX];
  assign o_pc                   = pc_ff;
  assign o_clear_from_writeback = wr0_pc || wr1_pc;
  assign o_init_busy            = (state_ff == INIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_ff <= INIT;
      cnt_ff   <= '0;
    end else begin
      state_ff <= state_nxt;
      cnt_ff   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_ff;
    cnt_nxt   = cnt_ff;
    if (state_ff == INIT) begin
      cnt_nxt = cnt_ff + IW'(1);
      if (32'(cnt_ff) == PHY_REGS - 1) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end
  end

  always_comb begin
    if (wr1_pc)          pc_raw = i_wr_data1;
    else if (wr0_pc)     pc_raw = i_wr_data0;
    else if (i_pc_load)  pc_raw = i_pc_load_value;
    else if (i_pc_stall) pc_raw = pc_ff;
    else                 pc_raw = pc_ff + (i_thumb ? DATA_WDT'(2) : DATA_WDT'(4));
    pc_nxt = {pc_raw[DATA_WDT-1:1], 1'b0};
  end

  // Port 1 is applied last so it wins a same-index collision; the PC slot
  // always takes the sequencer result, which already folds in port writes.
  always_comb begin
    for (int i = 0; i < PHY_REGS; i++) r_nxt[i] = r_ff[i];
    if (!i_reset) begin
      if (state_ff == INIT) begin
        r_nxt[cnt_ff] = '0;
      end else begin
        if (wr0_ok) r_nxt[i_wr_index0] = i_wr_data0;
        if (wr1_ok) r_nxt[i_wr_index1] = i_wr_data1;
        r_nxt[PC_IDX] = pc_nxt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_ff <= r_nxt;
  end

  always_comb begin
    o_rd_data = '0;
    rd_idx    = '0;
    rd_val    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_idx = i_rd_index[k*IW +: IW];
      rd_val = '0;
      if (run && legal_idx(rd_idx)) begin
        rd_val = r_ff[rd_idx];
        if (BYPASS != 0 && 32'(rd_idx) != PC_IDX) begin
          if (wr1_ok && rd_idx == i_wr_index1)      rd_val = i_wr_data1;
          else if (wr0_ok && rd_idx == i_wr_index0) rd_val = i_wr_data0;
        end
      end
      o_rd_data[k*DATA_WDT +: DATA_WDT] = rd_val;
    end
  end

endmodule

// File: tb/tb_zap_regf_multiport.sv
// Directed bench for zap_regf_multiport: scrub, collisions, PC sequencing,
// writeback-to-PC, RAZ/out-of-range handling and reset during scrub.
module tb_zap_regf_multiport;
  localparam int PHY_REGS = 46;
  localparam int DATA_WDT = 32;
  localparam int NUM_RD   = 4;
  localparam int IW       = 6;
  localparam int PC_IDX   = 15;
  localparam int RAZ_IDX  = 45;

  logic                       i_clk = 1'b0;
  logic                       i_reset;
  logic [NUM_RD*IW-1:0]       i_rd_index;
  logic [NUM_RD*DATA_WDT-1:0] o_rd_data;
  logic                       i_wr_en0, i_wr_en1;
  logic [IW-1:0]              i_wr_index0, i_wr_index1;
  logic [DATA_WDT-1:0]        i_wr_data0, i_wr_data1;
  logic                       i_pc_load, i_pc_stall, i_thumb;
  logic [DATA_WDT-1:0]        i_pc_load_value;
  logic [DATA_WDT-1:0]        o_pc;
  logic                       o_clear_from_writeback, o_init_busy;

  int n_cmp = 0;
  int n_err = 0;

  zap_regf_multiport #(
    .PHY_REGS(PHY_REGS), .DATA_WDT(DATA_WDT), .NUM_RD(NUM_RD),
    .BYPASS(1), .PC_IDX(PC_IDX), .RAZ_IDX(RAZ_IDX)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rd_index(i_rd_index), .o_rd_data(o_rd_data),
    .i_wr_en0(i_wr_en0), .i_wr_index0(i_wr_index0), .i_wr_data0(i_wr_data0),
    .i_wr_en1(i_wr_en1), .i_wr_index1(i_wr_index1), .i_wr_data1(i_wr_data1),
    .i_pc_load(i_pc_load), .i_pc_load_value(i_pc_load_value),
    .i_pc_stall(i_pc_stall), .i_thumb(i_thumb),
    .o_pc(o_pc), .o_clear_from_writeback(o_clear_from_writeback),
    .o_init_busy(o_init_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [DATA_WDT-1:0] rd(input int k);
    return o_rd_data[k*DATA_WDT +: DATA_WDT];
  endfunction

  task automatic set_rd(input int k, input int idx);
    i_rd_index[k*IW +: IW] = IW'(idx);
  endtask

  task automatic idle;
    i_wr_en0 = 1'b0; i_wr_index0 = '0; i_wr_data0 = '0;
    i_wr_en1 = 1'b0; i_wr_index1 = '0; i_wr_data1 = '0;
    i_pc_load = 1'b0; i_pc_load_value = '0;
    i_pc_stall = 1'b1; i_thumb = 1'b0;
  endtask

  // Counts cycles with o_init_busy high, bounded so a stuck FSM still ends.
  task automatic count_busy(output int n);
    n = 0;
    while (o_init_busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    int n;
    idle();
    i_rd_index = '0;
    set_rd(1, 3); set_rd(2, 15); set_rd(3, 44);
    i_reset = 1'b1;
    tick(); tick();
    n_cmp++; if (o_init_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", o_init_busy); end
    n_cmp++; if (o_clear_from_writeback !== 1'b0) begin n_err++; $display("FAIL reset_clear: got %b want 0", o_clear_from_writeback); end
    n_cmp++; if (o_rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", o_rd_data); end
    i_reset = 1'b0;
    count_busy(n);
    n_cmp++; if (n != 46) begin n_err++; $display("FAIL reset_busy_cycles: got %0d want 46", n); end
    for (int r = 0; r < PHY_REGS; r++) begin
      set_rd(r % NUM_RD, r);
      #1;
      n_cmp++; if (rd(r % NUM_RD) !== 32'h0) begin n_err++; $display("FAIL reset_zero_r%0d: got %h want 0", r, rd(r % NUM_RD)); end
    end
    n_cmp++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", o_pc); end
  endtask

  task automatic test_scrub;
    int n;
    idle();
    for (int r = 0; r < PHY_REGS; r++) begin
      i_wr_en0 = 1'b1; i_wr_index0 = IW'(r); i_wr_data0 = 32'hA5A5_0000 | r;
      tick();
    end
    idle();
    set_rd(0, 10);
    #1;
    n_cmp++; if (rd(0) !== 32'hA5A5_000A) begin n_err++; $display("FAIL scrub_preload: got %h want a5a5000a", rd(0)); end
    n_cmp++; if (o_pc !== 32'hA5A5_000E) begin n_err++; $display("FAIL scrub_preload_pc: got %h want a5a5000e", o_pc); end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    count_busy(n);
    n_cmp++; if (n != 46) begin n_err++; $display("FAIL scrub_busy_cycles: got %0d want 46", n); end
    for (int r = 0; r < PHY_REGS; r++) begin
      set_rd(r % NUM_RD, r);
      #1;
      n_cmp++; if (rd(r % NUM_RD) !== 32'h0) begin n_err++; $display("FAIL scrub_zero_r%0d: got %h want 0", r, rd(r % NUM_RD)); end
    end
    n_cmp++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL scrub_pc: got %h want 0", o_pc); end
  endtask

  task automatic test_collision;
    idle();
    set_rd(0, 3); set_rd(1, 7);
    i_wr_en0 = 1'b1; i_wr_index0 = 6'd3; i_wr_data0 = 32'h1111_1111;
    i_wr_en1 = 1'b1; i_wr_index1 = 6'd3; i_wr_data1 = 32'h2222_2222;
    #1;
    n_cmp++; if (rd(0) !== 32'h2222_2222) begin n_err++; $display("FAIL collision_bypass: got %h want 22222222", rd(0)); end
    n_cmp++; if (rd(1) !== 32'h0) begin n_err++; $display("FAIL collision_other: got %h want 0", rd(1)); end
    tick();
    idle();
    #1;
    n_cmp++; if (rd(0) !== 32'h2222_2222) begin n_err++; $display("FAIL collision_stored: got %h want 22222222", rd(0)); end
    i_wr_en0 = 1'b1; i_wr_index0 = 6'd7; i_wr_data0 = 32'h1234_5678;
    #1;
    n_cmp++; if (rd(1) !== 32'h1234_5678) begin n_err++; $display("FAIL bypass_port0: got %h want 12345678", rd(1)); end
    tick();
    idle();
    #1;
    n_cmp++; if (rd(1) !== 32'h1234_5678) begin n_err++; $display("FAIL write_port0: got %h want 12345678", rd(1)); end
  endtask

  task automatic test_pc_seq;
    logic [DATA_WDT-1:0] exp_pc [3];
    exp_pc[0] = 32'h104; exp_pc[1] = 32'h108; exp_pc[2] = 32'h10C;
    idle();
    i_pc_load = 1'b1; i_pc_load_value = 32'h100;
    tick();
    n_cmp++; if (o_pc !== 32'h100) begin n_err++; $display("FAIL pc_load_100: got %h want 100", o_pc); end
    i_pc_load = 1'b0; i_pc_stall = 1'b0; i_thumb = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (o_pc !== exp_pc[c]) begin n_err++; $display("FAIL pc_arm_step%0d: got %h want %h", c, o_pc, exp_pc[c]); end
    end
    i_thumb = 1'b1;
    tick();
    n_cmp++; if (o_pc !== 32'h10E) begin n_err++; $display("FAIL pc_thumb: got %h want 10e", o_pc); end
    i_pc_stall = 1'b1;
    tick();
    n_cmp++; if (o_pc !== 32'h10E) begin n_err++; $display("FAIL pc_stall: got %h want 10e", o_pc); end
    i_pc_load = 1'b1; i_pc_load_value = 32'h2001;
    tick();
    idle();
    n_cmp++; if (o_pc !== 32'h2000) begin n_err++; $display("FAIL pc_load_over_stall: got %h want 2000", o_pc); end
  endtask

  task automatic test_pc_writeback;
    idle();
    set_rd(0, PC_IDX);
    i_wr_en0 = 1'b1; i_wr_index0 = 6'd15; i_wr_data0 = 32'h4000;
    i_pc_load = 1'b1; i_pc_load_value = 32'h800;
    #1;
    n_cmp++; if (o_clear_from_writeback !== 1'b1) begin n_err++; $display("FAIL wb_clear: got %b want 1", o_clear_from_writeback); end
    n_cmp++; if (rd(0) !== 32'h2000) begin n_err++; $display("FAIL wb_pc_no_bypass: got %h want 2000", rd(0)); end
    tick();
    idle();
    #1;
    n_cmp++; if (o_pc !== 32'h4000) begin n_err++; $display("FAIL wb_pc: got %h want 4000", o_pc); end
    n_cmp++; if (o_clear_from_writeback !== 1'b0) begin n_err++; $display("FAIL wb_clear_idle: got %b want 0", o_clear_from_writeback); end
    i_wr_en0 = 1'b1; i_wr_index0 = 6'd15; i_wr_data0 = 32'h5000;
    i_wr_en1 = 1'b1; i_wr_index1 = 6'd15; i_wr_data1 = 32'h6001;
    tick();
    idle();
    n_cmp++; if (o_pc !== 32'h6000) begin n_err++; $display("FAIL wb_port1_pc: got %h want 6000", o_pc); end
  endtask

  task automatic test_raz_range;
    idle();
    set_rd(0, RAZ_IDX); set_rd(1, 50); set_rd(2, 46); set_rd(3, 3);
    i_wr_en0 = 1'b1; i_wr_index0 = 6'd45; i_wr_data0 = 32'hDEAD_BEEF;
    i_wr_en1 = 1'b1; i_wr_index1 = 6'd50; i_wr_data1 = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (rd(0) !== 32'h0) begin n_err++; $display("FAIL raz_bypass: got %h want 0", rd(0)); end
    n_cmp++; if (rd(1) !== 32'h0) begin n_err++; $display("FAIL oor_bypass: got %h want 0", rd(1)); end
    n_cmp++; if (o_clear_from_writeback !== 1'b0) begin n_err++; $display("FAIL raz_clear: got %b want 0", o_clear_from_writeback); end
    tick();
    idle();
    #1;
    n_cmp++; if (rd(0) !== 32'h0) begin n_err++; $display("FAIL raz_read: got %h want 0", rd(0)); end
    n_cmp++; if (rd(1) !== 32'h0) begin n_err++; $display("FAIL oor_read50: got %h want 0", rd(1)); end
    n_cmp++; if (rd(2) !== 32'h0) begin n_err++; $display("FAIL oor_read46: got %h want 0", rd(2)); end
    n_cmp++; if (rd(3) !== 32'h2222_2222) begin n_err++; $display("FAIL raz_keep_r3: got %h want 22222222", rd(3)); end
    n_cmp++; if (o_pc !== 32'h6000) begin n_err++; $display("FAIL raz_keep_pc: got %h want 6000", o_pc); end
    set_rd(3, 7);
    #1;
    n_cmp++; if (rd(3) !== 32'h1234_5678) begin n_err++; $display("FAIL raz_keep_r7: got %h want 12345678", rd(3)); end
    i_wr_en1 = 1'b1; i_wr_index1 = 6'd44; i_wr_data1 = 32'hCAFE_F00D;
    set_rd(2, 44);
    tick();
    idle();
    #1;
    n_cmp++; if (rd(2) !== 32'hCAFE_F00D) begin n_err++; $display("FAIL last_legal_r44: got %h want cafef00d", rd(2)); end
  endtask

  task automatic test_reset_mid_scrub;
    int n;
    idle();
    set_rd(0, 44); set_rd(1, PC_IDX); set_rd(2, 7);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_wr_en0 = 1'b1; i_wr_index0 = 6'd15; i_wr_data0 = 32'h1234_5678;
    i_wr_en1 = 1'b1; i_wr_index1 = 6'd44; i_wr_data1 = 32'h7777_7777;
    i_pc_load = 1'b1; i_pc_load_value = 32'h300; i_pc_stall = 1'b0;
    repeat (20) tick();
    n_cmp++; if (o_init_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", o_init_busy); end
    n_cmp++; if (o_clear_from_writeback !== 1'b0) begin n_err++; $display("FAIL mid_clear: got %b want 0", o_clear_from_writeback); end
    n_cmp++; if (rd(0) !== 32'h0) begin n_err++; $display("FAIL mid_rd_zero: got %h want 0", rd(0)); end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    count_busy(n);
    idle();
    #1;
    n_cmp++; if (n != 46) begin n_err++; $display("FAIL mid_busy_cycles: got %0d want 46", n); end
    n_cmp++; if (rd(0) !== 32'h0) begin n_err++; $display("FAIL mid_r44: got %h want 0", rd(0)); end
    n_cmp++; if (rd(1) !== 32'h0) begin n_err++; $display("FAIL mid_r15: got %h want 0", rd(1)); end
    n_cmp++; if (rd(2) !== 32'h0) begin n_err++; $display("FAIL mid_r7: got %h want 0", rd(2)); end
    n_cmp++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL mid_pc: got %h want 0", o_pc); end
  endtask

  initial begin
    i_reset = 1'b1;
    idle();
    i_rd_index = '0;
    test_reset();
    test_scrub();
    test_collision();
    test_pc_seq();
    test_pc_writeback();
    test_raz_range();
    test_reset_mid_scrub();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zap_regf_multiport.md
# zap_regf_multiport

Parametrised register-file core for the ZAP writeback stage. It holds PHY_REGS registers of DATA_WDT bits, with NUM_RD combinational read ports, two prioritised write ports and an optional write-to-read bypass. It also contains a dedicated PC sequencer and a post-reset scrub state machine that zeroes every register serially before the pipeline is released. It sits where the register file sits today, feeding the issue stage and the fetch PC.

## Interface
- PHY_REGS, 46: number of physical registers; index width IW = $clog2(PHY_REGS).
- DATA_WDT, 32: register width, minimum 2.
- NUM_RD, 4: number of read ports, 1..8.
- BYPASS, 1: 1 enables write-to-read forwarding; 0 disables it.
- PC_IDX, 15: physical index of the PC.
- RAZ_IDX, 45: physical index of the read-as-zero register.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset, synchronous, active-high; clock i_clk.
- i_rd_index  in  NUM_RD*IW  packed read indices; port k is bits [k*IW +: IW].
- o_rd_data  out  NUM_RD*DATA_WDT  packed read data; port k is bits [k*DATA_WDT +: DATA_WDT].
- i_wr_en0 / i_wr_index0 / i_wr_data0  in  1/IW/DATA_WDT  write port 0 (ALU result).
- i_wr_en1 / i_wr_index1 / i_wr_data1  in  1/IW/DATA_WDT  write port 1 (memory load); has priority over port 0.
- i_pc_load  in  1  load the PC from i_pc_load_value (branch or clear from ALU).
- i_pc_load_value  in  DATA_WDT  new PC value.
- i_pc_stall  in  1  hold the PC.
- i_thumb  in  1  selects the PC increment: 1 increments by 2, 0 increments by 4.
- o_pc  out  DATA_WDT  registered PC, r_ff[PC_IDX].
- o_clear_from_writeback  out  1  a write port targets PC_IDX this cycle.
- o_init_busy  out  1  the scrub state machine is running.

## Operation
- State machine: INIT and RUN. i_reset forces INIT with the scrub counter at 0, and asserting i_reset mid-scrub restarts the counter.
- INIT:
  - Each cycle writes 0 to r[cnt] and increments cnt.
  - After writing r[PHY_REGS-1], the next state is RUN.
  - o_init_busy is 1 throughout INIT.
  - All read ports return 0.
  - Write ports, i_pc_load and PC increment are ignored.
  - o_clear_from_writeback is 0.
  - o_pc reads whatever r_ff[PC_IDX] holds, which is 0 once slot PC_IDX has been scrubbed.
- RUN, write ports:
  - A port writes only when it is enabled and its index is less than PHY_REGS and not equal to RAZ_IDX.
  - If both ports write the same index, port 1's data is stored.
  - r[RAZ_IDX] always reads 0.
- RUN, next PC, in priority order:
  1. A port write to PC_IDX stores that port's data (port 1 wins over port 0).
  2. Otherwise, i_pc_load stores i_pc_load_value.
  3. Otherwise, i_pc_stall holds the current value.
  4. Otherwise, the PC increments by 2 or 4 per i_thumb; the add is DATA_WDT bits and wraps modulo 2^DATA_WDT.
- Bit 0 of the stored PC is always 0.
- o_clear_from_writeback is combinational. It is 1 in RUN when any enabled, in-range port write has index PC_IDX.
- Reads are combinational from r_ff:
  - An index of PHY_REGS or above returns 0.
  - RAZ_IDX returns 0.
  - When BYPASS=1, a read whose index matches an enabled, legal write this cycle returns the write data (port 1 first). The exception is PC_IDX, which always returns r_ff.

## Timing
- Reset values: o_init_busy=1, o_clear_from_writeback=0, o_rd_data=0. o_pc becomes 0 once the scrub passes PC_IDX.
- The scrub lasts exactly PHY_REGS cycles after the cycle in which i_reset is deasserted. o_init_busy falls at the clock edge that completes r[PHY_REGS-1].
- Write latency: one cycle, visible in r_ff after the next rising edge. With BYPASS=1 a written value is visible on reads in the same cycle.
- PC update latency: one cycle. o_clear_from_writeback is asserted in the same cycle as the PC write.

## Test plan
- Reset scrub: preload garbage, then assert i_reset for one cycle and deassert -> o_init_busy is 1 for exactly 46 cycles; afterwards all 46 registers read 0 and o_pc=0.
- Collision: in RUN, write r3 with port 0 = 0x11111111 and port 1 = 0x22222222 -> r3 reads 0x22222222 next cycle; with BYPASS=1, a same-cycle read of r3 returns 0x22222222.
- PC sequencing:
  - i_thumb=0 from PC 0x100 for 3 cycles -> 0x104, 0x108, 0x10C.
  - Then i_thumb=1 -> 0x10E.
  - Then i_pc_stall -> holds 0x10E.
  - Then i_pc_stall=1 with i_pc_load=1 and value 0x2001 -> PC is 0x2000.
- Writeback to PC: port 0 writes PC_IDX = 0x4000 while i_pc_load=1 with value 0x800 -> o_clear_from_writeback=1 that cycle; next o_pc=0x4000.
- RAZ and out-of-range: write 0xDEADBEEF to index 45 and to index 50 -> both read 0, no other register changes, o_clear_from_writeback=0.
- Reset mid-scrub: assert i_reset at scrub cycle 20 -> counter restarts; o_init_busy stays 1 for 46 cycles after deassertion; writes issued during the scrub have no effect.
